// File: rtl/cam_frame_capture_sram_pkg.sv
// Shared definitions for the camera frame-capture path.
//   - cap_state_t : capture FSM encoding
//   - DEF_H_ACTIVE / DEF_V_ACTIVE : default frame geometry
//   - SRAM_AW / SRAM_DW : external SRAM word-address / data widths
package cam_frame_capture_sram_pkg;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned SRAM_AW      = 19;
    localparam int unsigned SRAM_DW      = 16;

    typedef logic [SRAM_AW-1:0] sram_addr_t;
    typedef logic [SRAM_DW-1:0] sram_data_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_VS,
        S_WAIT_FS,
        S_CAPTURE,
        S_DONE
    } cap_state_t;

endpackage

// File: rtl/cam_frame_capture_sram_packer.sv
// rgb565_byte_packer: joins two consecutive camera bytes into one RGB565 pixel.
// First byte of a pair is held as pixel[15:8]; the second byte completes it.
// Ports:
//   pclk, rst     : clock, synchronous active-high reset
//   clear_i       : force byte phase back to 0 (outside an active capture)
//   valid_i       : byte_i carries a valid camera byte this cycle
//   byte_i [7:0]  : camera byte
//   pix_valid_o   : combinational, high on the cycle the second byte is present
//   pix_o  [15:0] : {held high byte, byte_i}, meaningful when pix_valid_o=1
module rgb565_byte_packer (
    input  logic        pclk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        valid_i,
    input  logic [7:0]  byte_i,
    output logic        pix_valid_o,
    output logic [15:0] pix_o
);

    logic       phase_q, phase_d;
    logic [7:0] hi_q, hi_d;

    // A gap in valid_i resets the phase, so an odd trailing byte is dropped.
    always_comb begin
        phase_d = phase_q;
        hi_d    = hi_q;
        if (clear_i || !valid_i) begin
            phase_d = 1'b0;
        end else begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = byte_i;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            phase_q <= 1'b0;
            hi_q    <= '0;
        end else begin
            phase_q <= phase_d;
            hi_q    <= hi_d;
        end
    end

    assign pix_valid_o = valid_i && phase_q && !clear_i;
    assign pix_o       = {hi_q, byte_i};

endmodule

// File: rtl/cam_frame_capture_sram.sv
// cam_frame_capture_sram: captures one RGB565 frame from a vsync/href byte
// stream and writes it to external SRAM at BASE_ADDR + pixel index.
// Optional build macro: FRAME_CHECK_EN (burst-length / line-count checker
// driving frame_err; when undefined frame_err is tied 0).
// Ports:
//   pclk, rst          : pixel clock, synchronous active-high reset
//   enable             : level request to capture one frame
//   vsync, href        : camera frame sync / line valid
//   cam_data [7:0]     : camera byte, first byte of a pair = pixel[15:8]
//   selec_sram         : SRAM bus ownership request
//   write_sram         : one-cycle write strobe
//   read_sram          : always 0
//   addr_sram [18:0]   : write address
//   data_sram [15:0]   : write data
//   done               : frame stored, held until enable drops
//   frame_err          : sticky framing error for the current frame
module cam_frame_capture_sram
    import cam_frame_capture_sram_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter sram_addr_t  BASE_ADDR = 19'd0
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  cam_data,
    output logic        selec_sram,
    output logic        write_sram,
    output logic        read_sram,
    output logic [18:0] addr_sram,
    output logic [15:0] data_sram,
    output logic        done,
    output logic        frame_err
);

    localparam int unsigned TOTAL    = H_ACTIVE * V_ACTIVE;
    // Index of the final pixel; TOTAL itself may be 2^19 and not fit the counter.
    localparam sram_addr_t  LAST_IDX = SRAM_AW'(TOTAL - 1);

    cap_state_t state_q, state_d;
    sram_addr_t addr_q, addr_d;
    sram_addr_t cnt_q, cnt_d;
    sram_data_t data_q, data_d;
    logic       write_q, write_d;
    logic       last_q, last_d;

    logic       pk_clear, pk_valid, pix_valid;
    logic [15:0] pix;

    // Bytes are accepted only while actively capturing; a terminating vsync or
    // an already-written final pixel blocks any further pixel.
    assign pk_clear = (state_q != S_CAPTURE);
    assign pk_valid = (state_q == S_CAPTURE) && enable && href && !vsync && !last_q;

    rgb565_byte_packer u_packer (
        .pclk        (pclk),
        .rst         (rst),
        .clear_i     (pk_clear),
        .valid_i     (pk_valid),
        .byte_i      (cam_data),
        .pix_valid_o (pix_valid),
        .pix_o       (pix)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        write_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_WAIT_VS;
            end
            S_WAIT_VS: begin
                if (!enable)    state_d = S_IDLE;
                else if (vsync) state_d = S_WAIT_FS;
            end
            S_WAIT_FS: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (!vsync) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                    last_d  = 1'b0;
                end
            end
            S_CAPTURE: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (last_q || vsync) begin
                    // last_q is seen the cycle the final strobe is on the bus,
                    // so done follows that strobe by one cycle.
                    state_d = S_DONE;
                end else if (pix_valid) begin
                    write_d = 1'b1;
                    addr_d  = BASE_ADDR + cnt_q;
                    data_d  = pix;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    last_d  = (cnt_q == LAST_IDX);
                end
            end
            S_DONE: begin
                if (!enable) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) begin
            addr_d = '0;
            data_d = '0;
        end
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            write_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            write_q <= write_d;
        end
    end

    assign selec_sram = (state_q == S_WAIT_VS) || (state_q == S_WAIT_FS) ||
                        (state_q == S_CAPTURE);
    assign done       = (state_q == S_DONE);
    assign read_sram  = 1'b0;
    assign write_sram = write_q;
    assign addr_sram  = addr_q;
    assign data_sram  = data_q;

`ifdef FRAME_CHECK_EN
    logic [20:0] byte_cnt_q;
    logic [19:0] line_cnt_q;
    logic        err_q;
    logic        frame_start;

    assign frame_start = (state_q == S_WAIT_FS) && enable && !vsync;

    // A burst is closed on the first href-low cycle after it; its length and
    // the running line count are checked then and at a terminating vsync.
    always_ff @(posedge pclk) begin
        if (rst || frame_start) begin
            byte_cnt_q <= '0;
            line_cnt_q <= '0;
            err_q      <= 1'b0;
        end else if (state_q == S_CAPTURE) begin
            if (href) begin
                if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 1'b1;
            end else if (byte_cnt_q != '0) begin
                if (byte_cnt_q != 21'(2 * H_ACTIVE)) err_q <= 1'b1;
                if (line_cnt_q != '1) line_cnt_q <= line_cnt_q + 1'b1;
                byte_cnt_q <= '0;
            end
            if (vsync && (line_cnt_q != 20'(V_ACTIVE))) err_q <= 1'b1;
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

endmodule
